// File: rtl/stencil_kernel_ctrl_if.sv
// Kernel-side stream bundle for stencil_kernel_ctrl: node-data source, from_kernel
// data/ctrl streams towards the wrapper, and to_kernel ctrl/data streams back from it.
interface stencil_kernel_ctrl_if;
    // All streams: a beat transfers on a rising clk edge where tvalid && tready are both
    // high. A source keeps tvalid, tdata and tlast steady from assertion until that beat;
    // a sink may raise or drop tready in any cycle.
    logic [31:0] nd_tdata;
    logic        nd_tvalid;
    logic        nd_tready;
    logic        nd_tlast;

    logic [31:0] m_data_tdata;
    logic        m_data_tvalid;
    logic        m_data_tready;
    logic        m_data_tlast;

    logic [7:0]  m_ctrl_tdata;
    logic        m_ctrl_tvalid;
    logic        m_ctrl_tready;
    logic        m_ctrl_tlast;

    logic [7:0]  s_ctrl_tdata;
    logic        s_ctrl_tvalid;
    logic        s_ctrl_tready;

    logic [31:0] s_data_tdata;
    logic        s_data_tvalid;
    logic        s_data_tready;

    modport master (
        input  nd_tdata, nd_tvalid, nd_tlast,
        output nd_tready,
        output m_data_tdata, m_data_tvalid, m_data_tlast,
        input  m_data_tready,
        output m_ctrl_tdata, m_ctrl_tvalid, m_ctrl_tlast,
        input  m_ctrl_tready,
        input  s_ctrl_tdata, s_ctrl_tvalid,
        output s_ctrl_tready,
        input  s_data_tdata, s_data_tvalid,
        output s_data_tready
    );

    modport slave (
        output nd_tdata, nd_tvalid, nd_tlast,
        input  nd_tready,
        input  m_data_tdata, m_data_tvalid, m_data_tlast,
        output m_data_tready,
        input  m_ctrl_tdata, m_ctrl_tvalid, m_ctrl_tlast,
        output m_ctrl_tready,
        output s_ctrl_tdata, s_ctrl_tvalid,
        input  s_ctrl_tready,
        output s_data_tdata, s_data_tvalid,
        input  s_data_tready
    );
endinterface

// File: rtl/stencil_kernel_ctrl.sv
// Hardware stand-in for the Jacobi stencil kernel: forwards one node packet, does the clear
// handshake, then N start/done iterations capturing three stats words each.
// Optional watchdog on the response waits: define STENCIL_KERNEL_CTRL_TIMEOUT_EN.
module stencil_kernel_ctrl #(
    parameter logic [7:0] CMD_CLEAR = 8'h03,
    parameter logic [7:0] CMD_START = 8'h01,
    parameter logic [7:0] CMD_DONE  = 8'h01
`ifdef STENCIL_KERNEL_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [15:0] cfg_num_iters,
    stencil_kernel_ctrl_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [15:0] iter_count,
    output logic [31:0] stat0,
    output logic [31:0] stat1,
    output logic [31:0] stat2,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SEND_NODE  = 4'd1,
        SEND_CLEAR = 4'd2,
        WAIT_CLEAR = 4'd3,
        SEND_START = 4'd4,
        SEND_DONE  = 4'd5,
        WAIT_DONE  = 4'd6,
        READ_STATS = 4'd7,
        FINISH     = 4'd8
    } state_t;

    state_t      state_q;
    logic [15:0] iters_q;
    logic [15:0] iter_count_q;
    logic [1:0]  stat_idx_q;
    logic [31:0] stat0_q, stat1_q, stat2_q;
    logic        busy_q, done_q, err_code_q;

    logic nd_hs, ctrl_hs, s_ctrl_hs, s_data_hs;
    logic unused_ctrl_bits;

    assign nd_hs     = bus.nd_tvalid && bus.m_data_tready;
    assign ctrl_hs   = bus.m_ctrl_tvalid && bus.m_ctrl_tready;
    assign s_ctrl_hs = bus.s_ctrl_tvalid && bus.s_ctrl_tready;
    assign s_data_hs = bus.s_data_tvalid && bus.s_data_tready;
    assign unused_ctrl_bits = ^bus.s_ctrl_tdata[7:2];

    // Stream strobes decode directly from the state register so reset drops them at once.
    always_comb begin
        bus.nd_tready     = 1'b0;
        bus.m_data_tvalid = 1'b0;
        bus.m_data_tdata  = '0;
        bus.m_data_tlast  = 1'b0;
        bus.m_ctrl_tvalid = 1'b0;
        bus.m_ctrl_tdata  = '0;
        bus.m_ctrl_tlast  = 1'b0;
        bus.s_ctrl_tready = 1'b0;
        bus.s_data_tready = 1'b0;
        case (state_q)
            SEND_NODE: begin
                bus.m_data_tvalid = bus.nd_tvalid;
                bus.m_data_tdata  = bus.nd_tdata;
                bus.m_data_tlast  = bus.nd_tlast;
                bus.nd_tready     = bus.m_data_tready;
            end
            SEND_CLEAR: begin
                bus.m_ctrl_tvalid = 1'b1;
                bus.m_ctrl_tdata  = CMD_CLEAR;
                bus.m_ctrl_tlast  = 1'b1;
            end
            SEND_START: begin
                bus.m_ctrl_tvalid = 1'b1;
                bus.m_ctrl_tdata  = CMD_START;
                bus.m_ctrl_tlast  = 1'b1;
            end
            SEND_DONE: begin
                bus.m_ctrl_tvalid = 1'b1;
                bus.m_ctrl_tdata  = CMD_DONE;
                bus.m_ctrl_tlast  = 1'b1;
            end
            WAIT_CLEAR, WAIT_DONE: bus.s_ctrl_tready = 1'b1;
            READ_STATS:            bus.s_data_tready = 1'b1;
            default: ;
        endcase
    end

`ifdef STENCIL_KERNEL_CTRL_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        err_to_q;
    logic        wd_active, wd_exit, wd_fire;

    assign wd_active = state_q inside {WAIT_CLEAR, SEND_DONE, WAIT_DONE};
    assign wd_exit   = ctrl_hs || s_ctrl_hs;
    assign wd_fire   = wd_active && !wd_exit && (wd_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (state_q == IDLE && cfg_start)
                err_to_q <= 1'b0;
            else if (wd_fire)
                err_to_q <= 1'b1;
            if (!wd_active || wd_exit || wd_fire)
                wd_q <= '0;
            else
                wd_q <= wd_q + 32'd1;
        end
    end

    assign error = {err_to_q, err_code_q};
`else
    assign error = {1'b0, err_code_q};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            iters_q      <= '0;
            iter_count_q <= '0;
            stat_idx_q   <= '0;
            stat0_q      <= '0;
            stat1_q      <= '0;
            stat2_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_code_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cfg_start) begin
                    iters_q      <= cfg_num_iters;
                    iter_count_q <= '0;
                    err_code_q   <= 1'b0;
                    busy_q       <= 1'b1;
                    state_q      <= SEND_NODE;
                end
                SEND_NODE:  if (nd_hs && bus.nd_tlast) state_q <= SEND_CLEAR;
                SEND_CLEAR: if (ctrl_hs) state_q <= WAIT_CLEAR;
                WAIT_CLEAR: if (s_ctrl_hs) begin
                    if (bus.s_ctrl_tdata[1:0] != 2'b11) err_code_q <= 1'b1;
                    if (iters_q != 16'd0) begin
                        state_q <= SEND_START;
                    end else begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                SEND_START: if (ctrl_hs) state_q <= SEND_DONE;
                SEND_DONE:  if (ctrl_hs) state_q <= WAIT_DONE;
                WAIT_DONE: if (s_ctrl_hs) begin
                    if (!bus.s_ctrl_tdata[0]) err_code_q <= 1'b1;
                    stat_idx_q <= 2'd0;
                    state_q    <= READ_STATS;
                end
                READ_STATS: if (s_data_hs) begin
                    stat_idx_q <= stat_idx_q + 2'd1;
                    case (stat_idx_q)
                        2'd0: stat0_q <= bus.s_data_tdata;
                        2'd1: stat1_q <= bus.s_data_tdata;
                        default: begin
                            stat2_q      <= bus.s_data_tdata;
                            iter_count_q <= iter_count_q + 16'd1;
                            // 17-bit compare: iters_q may be 65535, the largest count.
                            if ({1'b0, iter_count_q} + 17'd1 < {1'b0, iters_q}) begin
                                state_q <= SEND_START;
                            end else begin
                                state_q <= FINISH;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    endcase
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
`ifdef STENCIL_KERNEL_CTRL_TIMEOUT_EN
            if (wd_fire) begin
                state_q <= FINISH;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign iter_count = iter_count_q;
    assign stat0      = stat0_q;
    assign stat1      = stat1_q;
    assign stat2      = stat2_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_stencil_kernel_ctrl.sv
// Bench for stencil_kernel_ctrl: acts as node source and as the stencil wrapper,
// with scoreboard queues for the m_data and m_ctrl streams.
module tb_stencil_kernel_ctrl;

    localparam logic [7:0] CMD_CLEAR = 8'h03;
    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_DONE  = 8'h01;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_num_iters = '0;
    logic        busy, done;
    logic [1:0]  error;
    logic [15:0] iter_count;
    logic [31:0] stat0, stat1, stat2;
    logic [3:0]  dbg_state;

    stencil_kernel_ctrl_if bus ();

`ifdef STENCIL_KERNEL_CTRL_TIMEOUT_EN
    stencil_kernel_ctrl #(.TIMEOUT_CYCLES(100)) dut (
`else
    stencil_kernel_ctrl dut (
`endif
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_num_iters(cfg_num_iters),
        .bus(bus), .busy(busy), .done(done), .error(error), .iter_count(iter_count),
        .stat0(stat0), .stat1(stat1), .stat2(stat2), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n_words;
        logic [15:0] iters;
        logic [7:0]  clr_resp;
        logic [7:0]  done_resp;
        logic [31:0] st_base;
        logic [15:0] exp_iter;
        logic [1:0]  exp_err;
        logic [31:0] exp_s0;
        logic [31:0] exp_s1;
        logic [31:0] exp_s2;
    } vec_t;

    vec_t vecs[5];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int ctrl_beats = 0;
    int data_beats = 0;
    int ctrl_mode = 0;  // 0 random m_ctrl_tready, 1 held low, 2 held high

    logic [8:0]  exp_ctrl_q[$];
    logic [32:0] exp_data_q[$];
    logic        ctrl_stalled = 1'b0;
    logic        data_stalled = 1'b0;
    logic [7:0]  ctrl_prev = '0;
    logic [32:0] data_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Ready generation for the streams the DUT drives.
    always @(posedge clk) begin
        #1;
        bus.m_data_tready = ($urandom_range(0, 3) != 0);
        if (ctrl_mode == 0) bus.m_ctrl_tready = ($urandom_range(0, 1) == 1);
        else                bus.m_ctrl_tready = (ctrl_mode == 2);
    end

    // Monitor: pops the scoreboard on every beat and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            ctrl_stalled = 1'b0;
            data_stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (bus.m_ctrl_tvalid) begin
                if (ctrl_stalled) check("ctrl_hold", bus.m_ctrl_tdata, ctrl_prev);
                if (bus.m_ctrl_tready) begin
                    ctrl_beats++;
                    ctrl_stalled = 1'b0;
                    if (exp_ctrl_q.size() == 0) fail("ctrl_extra_beat");
                    else check("ctrl_beat", {bus.m_ctrl_tlast, bus.m_ctrl_tdata}, exp_ctrl_q.pop_front());
                end else begin
                    ctrl_stalled = 1'b1;
                    ctrl_prev = bus.m_ctrl_tdata;
                end
            end else begin
                if (ctrl_stalled) fail("ctrl_valid_dropped");
                ctrl_stalled = 1'b0;
            end
            if (bus.m_data_tvalid) begin
                if (data_stalled) check("data_hold", {bus.m_data_tlast, bus.m_data_tdata}, data_prev);
                if (bus.m_data_tready) begin
                    data_beats++;
                    data_stalled = 1'b0;
                    if (exp_data_q.size() == 0) fail("data_extra_beat");
                    else check("data_beat", {bus.m_data_tlast, bus.m_data_tdata}, exp_data_q.pop_front());
                end else begin
                    data_stalled = 1'b1;
                    data_prev = {bus.m_data_tlast, bus.m_data_tdata};
                end
            end else begin
                data_stalled = 1'b0;
            end
        end
    end

    task automatic wait_ctrl(input int target);
        int  n = 0;
        logic waited = 1'b0;
        while (ctrl_beats < target) begin
            if (n >= 2000) begin
                fail("wait_ctrl_timeout");
                return;
            end
            @(posedge clk);
            n++;
            waited = 1'b1;
        end
        if (waited) #1;
    endtask

    task automatic drive_nd(input logic [31:0] d, input logic last);
        logic ok = 1'b0;
        exp_data_q.push_back({last, d});
        bus.nd_tdata = d;
        bus.nd_tlast = last;
        bus.nd_tvalid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.nd_tready) begin ok = 1'b1; break; end
        end
        if (!ok) fail("nd_timeout");
        @(posedge clk); #1;
        bus.nd_tvalid = 1'b0;
    endtask

    task automatic send_sctrl(input logic [7:0] b);
        logic ok = 1'b0;
        bus.s_ctrl_tdata = b;
        bus.s_ctrl_tvalid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.s_ctrl_tready) begin ok = 1'b1; break; end
        end
        if (!ok) fail("s_ctrl_timeout");
        @(posedge clk); #1;
        bus.s_ctrl_tvalid = 1'b0;
    endtask

    task automatic send_sdata(input logic [31:0] w);
        logic ok = 1'b0;
        bus.s_data_tdata = w;
        bus.s_data_tvalid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.s_data_tready) begin ok = 1'b1; break; end
        end
        if (!ok) fail("s_data_timeout");
        @(posedge clk); #1;
        bus.s_data_tvalid = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] n);
        done_cnt = 0;
        ctrl_beats = 0;
        data_beats = 0;
        @(posedge clk); #1;
        cfg_num_iters = n;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        check("busy_after_start", busy, 1);
        // A second request while busy must not relatch the count.
        cfg_num_iters = 16'h0007;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_finish();
        logic ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail("finish_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input logic [15:0] e_iter, input logic [1:0] e_err,
                              input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                              input int e_ctrl, input int e_data);
        check("done_pulses", done_cnt, 1);
        check("busy_idle", busy, 0);
        check("iter_count", iter_count, e_iter);
        check("error", error, e_err);
        check("stat0", stat0, s0);
        check("stat1", stat1, s1);
        check("stat2", stat2, s2);
        check("ctrl_beats", ctrl_beats, e_ctrl);
        check("data_beats", data_beats, e_data);
        check("ctrl_q_left", exp_ctrl_q.size(), 0);
        check("data_q_left", exp_data_q.size(), 0);
    endtask

    task automatic push_ctrl_seq(input int iters);
        exp_ctrl_q.push_back({1'b1, CMD_CLEAR});
        for (int i = 0; i < iters; i++) begin
            exp_ctrl_q.push_back({1'b1, CMD_START});
            exp_ctrl_q.push_back({1'b1, CMD_DONE});
        end
    endtask

    task automatic run_vec(input vec_t v);
        push_ctrl_seq(int'(v.iters));
        start_run(v.iters);
        for (int w = 0; w < v.n_words; w++) drive_nd($urandom, w == v.n_words - 1);
        wait_ctrl(1);
        send_sctrl(v.clr_resp);
        for (int it = 0; it < int'(v.iters); it++) begin
            wait_ctrl(3 + 2 * it);
            send_sctrl(v.done_resp);
            for (int k = 0; k < 3; k++) send_sdata(v.st_base + 32'(10 * k) + 32'(it));
        end
        wait_finish();
        end_checks(v.exp_iter, v.exp_err, v.exp_s0, v.exp_s1, v.exp_s2,
                   1 + 2 * int'(v.iters), v.n_words);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, {busy, done, error, iter_count}, 0);
        check({tag, "_stat0"}, stat0, 0);
        check({tag, "_stat1"}, stat1, 0);
        check({tag, "_stat2"}, stat2, 0);
        check({tag, "_strobes"}, {bus.nd_tready, bus.m_data_tvalid, bus.m_ctrl_tvalid,
                                  bus.s_ctrl_tready, bus.s_data_tready}, 0);
        check({tag, "_m_data"}, {bus.m_ctrl_tdata, bus.m_data_tdata}, 0);
    endtask

    initial begin
        int hold_ok;
        vecs[0] = '{n_words: 4, iters: 16'd2, clr_resp: 8'h03, done_resp: 8'h01, st_base: 32'd10,
                    exp_iter: 16'd2, exp_err: 2'b00, exp_s0: 32'd11, exp_s1: 32'd21, exp_s2: 32'd31};
        vecs[1] = '{n_words: 3, iters: 16'd0, clr_resp: 8'h03, done_resp: 8'h01, st_base: 32'd0,
                    exp_iter: 16'd0, exp_err: 2'b00, exp_s0: 32'd11, exp_s1: 32'd21, exp_s2: 32'd31};
        vecs[2] = '{n_words: 2, iters: 16'd1, clr_resp: 8'h01, done_resp: 8'h01, st_base: 32'd100,
                    exp_iter: 16'd1, exp_err: 2'b01, exp_s0: 32'd100, exp_s1: 32'd110, exp_s2: 32'd120};
        vecs[3] = '{n_words: 5, iters: 16'd3, clr_resp: 8'h03, done_resp: 8'h00, st_base: 32'd5,
                    exp_iter: 16'd3, exp_err: 2'b01, exp_s0: 32'd7, exp_s1: 32'd17, exp_s2: 32'd27};
        vecs[4] = '{n_words: 1, iters: 16'd1, clr_resp: 8'h03, done_resp: 8'h03, st_base: 32'hdead0000,
                    exp_iter: 16'd1, exp_err: 2'b00, exp_s0: 32'hdead0000, exp_s1: 32'hdead000a,
                    exp_s2: 32'hdead0014};

        bus.nd_tdata = '0; bus.nd_tvalid = 1'b0; bus.nd_tlast = 1'b0;
        bus.m_data_tready = 1'b0; bus.m_ctrl_tready = 1'b0;
        bus.s_ctrl_tdata = '0; bus.s_ctrl_tvalid = 1'b0;
        bus.s_data_tdata = '0; bus.s_data_tvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Stray beats while idle must be stalled and never forwarded.
        @(posedge clk); #1;
        bus.nd_tvalid = 1'b1; bus.nd_tdata = 32'h1234;
        bus.s_ctrl_tvalid = 1'b1; bus.s_ctrl_tdata = 8'h03;
        bus.s_data_tvalid = 1'b1; bus.s_data_tdata = 32'h55;
        repeat (4) @(negedge clk);
        check("idle_stray", {bus.nd_tready, bus.m_data_tvalid, bus.m_ctrl_tvalid,
                             bus.s_ctrl_tready, bus.s_data_tready}, 0);
        @(posedge clk); #1;
        bus.nd_tvalid = 1'b0; bus.s_ctrl_tvalid = 1'b0; bus.s_data_tvalid = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // m_ctrl_tready held low for 50 cycles while CMD_START is offered.
        push_ctrl_seq(1);
        start_run(16'd1);
        drive_nd(32'hcafe0001, 1'b1);
        wait_ctrl(1);
        ctrl_mode = 1;
        send_sctrl(8'h03);
        hold_ok = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.m_ctrl_tvalid && bus.m_ctrl_tdata == CMD_START) hold_ok++;
        end
        check("stall_hold_cycles", hold_ok, 50);
        check("stall_no_beat", ctrl_beats, 1);
        @(posedge clk); #1;
        ctrl_mode = 0;
        wait_ctrl(3);
        send_sctrl(8'h01);
        send_sdata(32'd40); send_sdata(32'd50); send_sdata(32'd60);
        wait_finish();
        end_checks(16'd1, 2'b00, 32'd40, 32'd50, 32'd60, 3, 1);

        // Asynchronous reset in the middle of the second READ_STATS phase.
        push_ctrl_seq(2);
        start_run(16'd2);
        drive_nd(32'h11, 1'b0);
        drive_nd(32'h22, 1'b1);
        wait_ctrl(1);
        send_sctrl(8'h03);
        wait_ctrl(3);
        send_sctrl(8'h01);
        send_sdata(32'd1); send_sdata(32'd2); send_sdata(32'd3);
        wait_ctrl(5);
        send_sctrl(8'h01);
        send_sdata(32'd77);
        check("pre_reset_stat0", stat0, 32'd77);
        check("pre_reset_iters", iter_count, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_ctrl_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(vecs[0]);

`ifdef STENCIL_KERNEL_CTRL_TIMEOUT_EN
        begin
            int cyc = 0;
            push_ctrl_seq(1);
            start_run(16'd1);
            drive_nd(32'h99, 1'b1);
            wait_ctrl(1);
            send_sctrl(8'h03);
            ctrl_mode = 2;
            wait_ctrl(3);
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                cyc++;
                if (done) break;
            end
            check("timeout_cycles", cyc, 101);
            #1;
            check("timeout_error", error, 2'b10);
            check("timeout_busy", busy, 0);
            check("timeout_iters", iter_count, 16'd0);
            ctrl_mode = 0;
        end
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stencil_kernel_ctrl.md
Name: stencil_kernel_ctrl

Overview:
- Kernel-side initiator for the Jacobi stencil wrapper protocol; drives the wrapper's from_kernel data/ctrl streams and consumes its to_kernel data/ctrl streams.
- Forwards one node-data packet, then performs the clear handshake.
- Runs N start/done iterations, capturing the three stats words returned after each iteration.
- Sits between host/test logic and the wrapper's kernel-facing AXI-Stream ports, replacing a software kernel in hardware-only tests.

Parameters:
- CMD_CLEAR, 8'h03, ctrl byte sent to acknowledge clear.
- CMD_START, 8'h01, ctrl byte sent to start an iteration.
- CMD_DONE, 8'h01, ctrl byte sent to acknowledge done.
- TIMEOUT_CYCLES, 1000000, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle start request; ignored while busy.
- cfg_num_iters  in  16  iteration count; latched on an accepted cfg_start.
- nd_tdata  in  32  node-data source stream.
- nd_tvalid  in  1  node-data source valid.
- nd_tready  out  1  node-data source ready.
- nd_tlast  in  1  marks the final node-data word.
- m_data_tdata/tvalid/tready(in)/tlast  out  32/1/1/1  to wrapper from_kernel data.
- m_ctrl_tdata/tvalid/tready(in)/tlast  out  8/1/1/1  to wrapper from_kernel_ctrl.
- s_ctrl_tdata/tvalid(in)/tready  in  8/1/1  from wrapper to_kernel_ctrl.
- s_data_tdata/tvalid(in)/tready  in  32/1/1  from wrapper to_kernel data (stats).
- busy  out  1  high from an accepted start until FINISH.
- done  out  1  one-cycle pulse in FINISH.
- error  out  2  sticky: bit0 = bad response code, bit1 = timeout.
- iter_count  out  16  completed iterations.
- stat0, stat1, stat2  out  32 each  stats words from the most recent iteration.

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0, including every valid/ready, error, iter_count and stats.
- States and transitions:
  - IDLE: accepted cfg_start latches cfg_num_iters, clears error and iter_count, sets busy -> SEND_NODE.
  - SEND_NODE: combinational pass-through. m_data_tvalid=nd_tvalid, nd_tready=m_data_tready, tdata/tlast copied. Handshake with nd_tlast -> SEND_CLEAR.
  - SEND_CLEAR: m_ctrl_tvalid=1, tdata=CMD_CLEAR, tlast=1. Handshake -> WAIT_CLEAR.
  - WAIT_CLEAR: s_ctrl_tready=1. On a beat, set error[0] if tdata[1:0]!=2'b11. Then -> SEND_START if latched iters!=0, else -> FINISH.
  - SEND_START: m_ctrl_tvalid=1, tdata=CMD_START. Handshake -> SEND_DONE.
  - SEND_DONE: m_ctrl_tvalid=1, tdata=CMD_DONE. Handshake -> WAIT_DONE. The wrapper accepts this only after computation finishes, so the stall here is normal.
  - WAIT_DONE: s_ctrl_tready=1. On a beat, set error[0] if tdata[0]==0. Then -> READ_STATS with stat_idx=0.
  - READ_STATS: s_data_tready=1. Each beat writes stat0/1/2 in order (stat_idx 0,1,2). The third beat increments iter_count, then -> SEND_START if iter_count+1 < latched iters, else -> FINISH.
  - FINISH: done=1 and busy=0 for exactly one cycle -> IDLE.
- Handshakes:
  - m_ctrl_tvalid stays high until accepted; tdata must not change while stalled.
  - s_* ready is asserted only in the wait/read states; stray beats elsewhere stall upstream.
  - m_data_* valid is 0 outside SEND_NODE; nd_tready is 0 outside SEND_NODE.
- Boundary conditions:
  - cfg_start while busy: ignored.
  - cfg_num_iters=0: clear handshake only, then FINISH with iter_count=0.
  - iter_count does not wrap: the maximum is 65535, which equals the latch limit.
  - An error does not abort the run; the flag is sticky until the next accepted start.
  - Reset mid-operation: immediate return to IDLE, all outputs cleared, no further beats issued.

Optional Feature:
- Macro STENCIL_KERNEL_CTRL_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles spent in WAIT_CLEAR, SEND_DONE or WAIT_DONE, and resets on every state change.
  - Reaching TIMEOUT_CYCLES sets error[1] and forces FINISH. done still pulses; iter_count holds the iterations completed so far.
- Undefined: no counter; the block waits indefinitely and error[1] is tied to 0.

Test Plan:
- 4-word node packet, then clear response 8'h03, then cfg_num_iters=2 with done responses 8'h01 and stats {10,20,30}/{11,21,31} -> m_data emits exactly 4 beats with tlast on the 4th. m_ctrl sequence is 03,01,01,01,01. iter_count=2, stat0..2=11,21,31, done pulses once, error=0.
- cfg_num_iters=0 -> after the clear handshake, FINISH directly; no CMD_START is issued; iter_count=0.
- Clear response 8'h01 -> error[0]=1; the run still completes; the next cfg_start clears error.
- m_ctrl_tready held low 50 cycles in SEND_START -> tvalid stays 1 and tdata stays 8'h01 throughout; exactly one beat transfers.
- reset_n pulsed low during READ_STATS after 1 stats word -> all outputs 0 asynchronously; a new run starts cleanly.
- With STENCIL_KERNEL_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, no done response sent -> after 100 cycles in WAIT_DONE: error=2'b10, done pulse, busy=0.
